// File: rtl/my_struct_s.sv
// Shared packet-buffer types: flit and metadata payloads, pktID/buffer widths, packet flag codes.
package my_struct_s;

    localparam int unsigned PKT_NUM       = 64;
    localparam int unsigned PKT_AWIDTH    = $clog2(PKT_NUM);
    localparam int unsigned FLIT_IDX_W    = 5;
    localparam int unsigned PKTBUF_AWIDTH = PKT_AWIDTH + FLIT_IDX_W;
    localparam int unsigned DATA_W        = 512;
    localparam int unsigned EMPTY_W       = 6;
    localparam int unsigned FLAGS_W       = 3;
    localparam int unsigned LEN_W         = 16;

    localparam logic [FLAGS_W-1:0] PKT_ETH  = 3'd1;
    localparam logic [FLAGS_W-1:0] PKT_PCIE = 3'd2;
    localparam logic [FLAGS_W-1:0] PKT_DROP = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } flit_t;

    typedef struct packed {
        logic [PKT_AWIDTH-1:0] pkt_id;
        logic [FLIT_IDX_W-1:0] flits;
        logic [LEN_W-1:0]      len;
        logic [FLAGS_W-1:0]    pkt_flags;
    } metadata_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_t;

    // Byte length of a packet: full 64-byte flits minus unused bytes of the last one.
    function automatic logic [LEN_W-1:0] flit_len(input logic [FLIT_IDX_W-1:0] flits,
                                                 input logic [EMPTY_W-1:0]    empty);
        return (LEN_W'(flits) << 6) - LEN_W'(empty);
    endfunction

endpackage

// File: rtl/pkt_buffer_writer_if.sv
// Bus bundle of the packet buffer writer: ingress, emptylist pop, buffer write, metadata, stats.
interface pkt_buffer_writer_if;
    import my_struct_s::*;

    logic                     in_pkt_valid;
    logic                     in_pkt_sop;
    logic                     in_pkt_eop;
    logic [DATA_W-1:0]        in_pkt_data;
    logic [EMPTY_W-1:0]       in_pkt_empty;
    logic [FLAGS_W-1:0]       in_pkt_flags;
    logic                     in_pkt_ready;

    logic [PKT_AWIDTH-1:0]    emptylist_out_data;
    logic                     emptylist_out_valid;
    logic                     emptylist_out_ready;

    logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address;
    logic                     pkt_buffer_write;
    flit_t                    pkt_buffer_writedata;

    logic                     meta_valid;
    metadata_t                meta_data;
    logic                     meta_ready;

    logic [31:0]              pkt_cnt;
    logic [31:0]              drop_cnt;

    modport master (
        input  in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_data, in_pkt_empty, in_pkt_flags,
        output in_pkt_ready,
        input  emptylist_out_data, emptylist_out_valid,
        output emptylist_out_ready,
        output pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
        output meta_valid, meta_data,
        input  meta_ready,
        output pkt_cnt, drop_cnt
    );

    modport slave (
        output in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_data, in_pkt_empty, in_pkt_flags,
        input  in_pkt_ready,
        output emptylist_out_data, emptylist_out_valid,
        input  emptylist_out_ready,
        input  pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
        input  meta_valid, meta_data,
        output meta_ready,
        input  pkt_cnt, drop_cnt
    );

endinterface

// File: rtl/pkt_buffer_writer.sv
// Writes ingress packets into per-pktID buffer slots and reports per-packet metadata.
// Packets without a free pktID, oversize tails and truncated packets are dropped.
module pkt_buffer_writer
    import my_struct_s::*;
#(
    parameter int unsigned MAX_FLITS = 31
) (
    input  logic                clk,
    input  logic                rst,
    pkt_buffer_writer_if.master bus
);

    localparam logic [FLIT_IDX_W-1:0] MAX_IDX = FLIT_IDX_W'(MAX_FLITS);

    wr_state_t             state_q, state_d;
    logic [PKT_AWIDTH-1:0] id_q, id_d;
    logic [FLAGS_W-1:0]    flags_q, flags_d;
    logic [FLIT_IDX_W-1:0] idx_q, idx_d;

    logic                  meta_free;
    logic                  accept;
    logic                  start;
    logic                  pop;
    logic                  wr_d;
    logic [PKT_AWIDTH-1:0] wr_id;
    logic [FLIT_IDX_W-1:0] wr_idx;
    logic                  close_d;
    logic [FLIT_IDX_W-1:0] close_flits;
    logic                  done_d;
    logic [FLIT_IDX_W-1:0] done_flits;
    logic [1:0]            drop_inc;

    metadata_t             close_meta, done_meta;
    metadata_t             pend0_q, pend0_d, pend1_q, pend1_d;
    logic [1:0]            pend_v_q, pend_v_d;

    assign meta_free               = !bus.meta_valid || bus.meta_ready;
    assign bus.in_pkt_ready        = !rst && meta_free;
    assign accept                  = bus.in_pkt_valid && bus.in_pkt_ready;
    assign bus.emptylist_out_ready = pop;

    // Packet FSM: decides per accepted flit whether it is written, closes a packet, or is discarded.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        flags_d     = flags_q;
        idx_d       = idx_q;
        start       = 1'b0;
        pop         = 1'b0;
        wr_d        = 1'b0;
        wr_id       = id_q;
        wr_idx      = idx_q;
        close_d     = 1'b0;
        close_flits = idx_q;
        done_d      = 1'b0;
        done_flits  = idx_q + FLIT_IDX_W'(1);
        drop_inc    = 2'd0;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: start = bus.in_pkt_sop;
                ST_WRITE: begin
                    if (bus.in_pkt_sop) begin
                        close_d  = 1'b1;
                        drop_inc = 2'd1;
                        start    = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (idx_q == MAX_IDX) begin
                        close_d     = 1'b1;
                        close_flits = MAX_IDX;
                        drop_inc    = 2'd1;
                        state_d     = bus.in_pkt_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_d  = 1'b1;
                        idx_d = idx_q + FLIT_IDX_W'(1);
                        if (bus.in_pkt_eop) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DROP: if (bus.in_pkt_eop) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            // New packet: claim a pktID if one is free, otherwise drop the whole packet
            if (start) begin
                if (bus.emptylist_out_valid) begin
                    pop     = 1'b1;
                    id_d    = bus.emptylist_out_data;
                    flags_d = bus.in_pkt_flags;
                    wr_d    = 1'b1;
                    wr_id   = bus.emptylist_out_data;
                    wr_idx  = '0;
                    idx_d   = FLIT_IDX_W'(1);
                    if (bus.in_pkt_eop) begin
                        done_d     = 1'b1;
                        done_flits = FLIT_IDX_W'(1);
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = bus.in_pkt_eop ? ST_IDLE : ST_DROP;
                end
            end
        end
    end

    assign close_meta = '{pkt_id: id_q, flits: close_flits,
                          len: flit_len(close_flits, EMPTY_W'(0)), pkt_flags: PKT_DROP};
    assign done_meta  = '{pkt_id: wr_id, flits: done_flits,
                          len: flit_len(done_flits, bus.in_pkt_empty), pkt_flags: flags_d};

    // Two-slot staging: one flit can close a truncated packet and complete a new one together.
    always_comb begin
        pend0_d  = pend0_q;
        pend1_d  = pend1_q;
        pend_v_d = pend_v_q;
        if (meta_free && pend_v_q[0]) begin
            pend0_d  = pend1_q;
            pend_v_d = {1'b0, pend_v_q[1]};
        end
        if (close_d) begin
            if (!pend_v_d[0]) begin
                pend0_d     = close_meta;
                pend_v_d[0] = 1'b1;
            end else begin
                pend1_d     = close_meta;
                pend_v_d[1] = 1'b1;
            end
        end
        if (done_d) begin
            if (!pend_v_d[0]) begin
                pend0_d     = done_meta;
                pend_v_d[0] = 1'b1;
            end else begin
                pend1_d     = done_meta;
                pend_v_d[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                  <= ST_IDLE;
            id_q                     <= '0;
            flags_q                  <= '0;
            idx_q                    <= '0;
            pend0_q                  <= '0;
            pend1_q                  <= '0;
            pend_v_q                 <= '0;
            bus.meta_valid           <= 1'b0;
            bus.meta_data            <= '0;
            bus.pkt_buffer_write     <= 1'b0;
            bus.pkt_buffer_address   <= '0;
            bus.pkt_buffer_writedata <= '0;
            bus.pkt_cnt              <= '0;
            bus.drop_cnt             <= '0;
        end else begin
            state_q              <= state_d;
            id_q                 <= id_d;
            flags_q              <= flags_d;
            idx_q                <= idx_d;
            pend0_q              <= pend0_d;
            pend1_q              <= pend1_d;
            pend_v_q             <= pend_v_d;
            bus.pkt_buffer_write <= wr_d;
            if (wr_d) begin
                bus.pkt_buffer_address   <= (PKTBUF_AWIDTH'(wr_id) << FLIT_IDX_W) + PKTBUF_AWIDTH'(wr_idx);
                bus.pkt_buffer_writedata <= '{data: bus.in_pkt_data, sop: start, eop: bus.in_pkt_eop,
                                              empty: bus.in_pkt_empty};
            end
            if (meta_free) begin
                bus.meta_valid <= pend_v_q[0];
                if (pend_v_q[0]) bus.meta_data <= pend0_q;
            end
            bus.pkt_cnt  <= bus.pkt_cnt + 32'(done_d);
            bus.drop_cnt <= bus.drop_cnt + 32'(drop_inc);
        end
    end

endmodule

// File: tb/tb_pkt_buffer_writer.sv
// Randomised scoreboard bench for pkt_buffer_writer with a packet-level reference model.
module tb_pkt_buffer_writer;
    import my_struct_s::*;

    localparam int MAXF = 31;

    typedef struct {
        logic [PKTBUF_AWIDTH-1:0] addr;
        flit_t                    f;
    } wexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pkt_buffer_writer_if bus();

    pkt_buffer_writer #(.MAX_FLITS(MAXF)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    wexp_t     wq[$];
    metadata_t mq[$];
    int        free_q[$];
    int        next_id = 0;

    // Reference model: mode 0 = between packets, 1 = storing, 2 = discarding to eop
    int              m_mode = 0;
    int              m_id = 0;
    int              m_cnt = 0;
    logic [2:0]      m_flags = '0;
    int              exp_pkts = 0;
    int              exp_drops = 0;

    bit el_avail = 1'b1;
    bit mr_random = 1'b0;
    bit bubbles = 1'b0;
    int hold_cnt = 0;

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic void push_write(int id, int idx, logic [511:0] d, bit sop, bit eop, logic [5:0] empty);
        wexp_t w;
        w.addr = PKTBUF_AWIDTH'(id * 32 + idx);
        w.f    = '{data: d, sop: sop, eop: eop, empty: empty};
        wq.push_back(w);
    endfunction

    function automatic void push_meta(int id, int flits, int len, logic [2:0] flags);
        mq.push_back('{pkt_id: PKT_AWIDTH'(id), flits: FLIT_IDX_W'(flits),
                       len: LEN_W'(len), pkt_flags: flags});
    endfunction

    function automatic bit model_accept(bit sop, bit eop, logic [511:0] d, logic [5:0] empty,
                                        logic [2:0] flags, bit id_free, int free_id);
        bit start = 1'b0;
        bit popped = 1'b0;
        if (m_mode == 1) begin
            if (sop) begin
                push_meta(m_id, m_cnt, m_cnt * 64, PKT_DROP);
                exp_drops++;
                m_mode = 0;
                start  = 1'b1;
            end else if (m_cnt == MAXF) begin
                push_meta(m_id, MAXF, MAXF * 64, PKT_DROP);
                exp_drops++;
                m_mode = eop ? 0 : 2;
            end else begin
                push_write(m_id, m_cnt, d, 1'b0, eop, empty);
                m_cnt++;
                if (eop) begin
                    push_meta(m_id, m_cnt, m_cnt * 64 - int'(empty), m_flags);
                    exp_pkts++;
                    m_mode = 0;
                end
            end
        end else if (m_mode == 2) begin
            if (eop) m_mode = 0;
        end else begin
            start = sop;
        end
        if (start) begin
            if (id_free) begin
                popped  = 1'b1;
                m_id    = free_id;
                m_flags = flags;
                m_cnt   = 1;
                push_write(m_id, 0, d, 1'b1, eop, empty);
                if (eop) begin
                    push_meta(m_id, 1, 64 - int'(empty), flags);
                    exp_pkts++;
                end else begin
                    m_mode = 1;
                end
            end else begin
                exp_drops++;
                m_mode = eop ? 0 : 2;
            end
        end
        return popped;
    endfunction

    task automatic drive_common();
        if (hold_cnt > 0) begin
            bus.meta_ready = 1'b0;
            hold_cnt--;
        end else begin
            bus.meta_ready = mr_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        while (free_q.size() < 4) begin
            free_q.push_back(next_id % PKT_NUM);
            next_id++;
        end
        bus.emptylist_out_valid = el_avail;
        bus.emptylist_out_data  = PKT_AWIDTH'(free_q[0]);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_common();
            bus.in_pkt_valid = 1'b0;
        end
    endtask

    task automatic send_flit(input bit sop, input bit eop, input logic [5:0] empty, input logic [2:0] flags);
        logic [511:0] d = rand_data();
        bit acc = 1'b0;
        bit popped;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            drive_common();
            bus.in_pkt_valid = !(bubbles && $urandom_range(0, 4) == 0);
            bus.in_pkt_sop   = sop;
            bus.in_pkt_eop   = eop;
            bus.in_pkt_data  = d;
            bus.in_pkt_empty = empty;
            bus.in_pkt_flags = flags;
            #1;
            if (bus.in_pkt_valid && bus.in_pkt_ready) begin
                acc    = 1'b1;
                popped = model_accept(sop, eop, d, empty, flags, el_avail, free_q[0]);
                check("emptylist_pop", 520'(bus.emptylist_out_ready), 520'(popped));
                if (popped) void'(free_q.pop_front());
            end
        end
        if (!acc) check("accept_timeout", 520'(0), 520'(1));
    endtask

    task automatic send_pkt(input int n, input bit with_eop, input logic [5:0] empty, input logic [2:0] flags);
        for (int i = 0; i < n; i++)
            send_flit(i == 0, with_eop && (i == n - 1), empty, flags);
    endtask

    task automatic drain();
        int c = 0;
        mr_random = 1'b0;
        while ((wq.size() != 0 || mq.size() != 0) && c < 2000) begin
            idle_cycles(1);
            c++;
        end
        idle_cycles(3);
        check("drain_writes_left", 520'(wq.size()), 520'(0));
        check("drain_meta_left", 520'(mq.size()), 520'(0));
    endtask

    // Monitor: compares every buffer write and every presented metadata word
    initial begin
        wexp_t w;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (bus.pkt_buffer_write) begin
                    if (wq.size() == 0) begin
                        check("unexpected_write", 520'(bus.pkt_buffer_address), 520'(0));
                    end else begin
                        w = wq.pop_front();
                        check("write_addr", 520'(bus.pkt_buffer_address), 520'(w.addr));
                        check("write_data", 520'(bus.pkt_buffer_writedata.data), 520'(w.f.data));
                        check("write_ctl", 520'({bus.pkt_buffer_writedata.sop, bus.pkt_buffer_writedata.eop,
                                                 bus.pkt_buffer_writedata.empty}),
                              520'({w.f.sop, w.f.eop, w.f.empty}));
                    end
                end
                if (bus.meta_valid) begin
                    if (mq.size() == 0) begin
                        check("unexpected_meta", 520'(bus.meta_data), 520'(0));
                    end else begin
                        check("meta", 520'(bus.meta_data), 520'(mq[0]));
                        if (bus.meta_ready) void'(mq.pop_front());
                        else check("ready_while_stalled", 520'(bus.in_pkt_ready), 520'(0));
                    end
                end
            end
        end
    end

    initial begin
        #(500_000 * 10);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_pkt_valid = 1'b0;
        bus.in_pkt_sop   = 1'b0;
        bus.in_pkt_eop   = 1'b0;
        bus.in_pkt_data  = '0;
        bus.in_pkt_empty = '0;
        bus.in_pkt_flags = '0;
        bus.meta_ready   = 1'b1;
        bus.emptylist_out_valid = 1'b0;
        bus.emptylist_out_data  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", 520'(bus.in_pkt_ready), 520'(0));
        check("rst_write", 520'(bus.pkt_buffer_write), 520'(0));
        check("rst_meta_valid", 520'(bus.meta_valid), 520'(0));
        check("rst_el_ready", 520'(bus.emptylist_out_ready), 520'(0));
        check("rst_pkt_cnt", 520'(bus.pkt_cnt), 520'(0));
        check("rst_drop_cnt", 520'(bus.drop_cnt), 520'(0));
        rst = 1'b0;

        // 4-flit packet into pktID 7
        free_q = {7};
        next_id = 8;
        send_pkt(4, 1'b1, 6'd10, PKT_ETH);
        drain();

        // 1-flit packet with no free pktID, then a normal one
        el_avail = 1'b0;
        send_pkt(1, 1'b1, 6'd0, PKT_PCIE);
        el_avail = 1'b1;
        send_pkt(2, 1'b1, 6'd5, PKT_PCIE);
        drain();
        check("drop_cnt_after_nofree", 520'(bus.drop_cnt), 520'(exp_drops));

        // 40-flit oversize packet into pktID 3
        free_q = {3};
        send_pkt(40, 1'b1, 6'd0, PKT_ETH);
        drain();

        // Missing eop: sop on flit 3 of pktID 5, next pktID 6
        free_q = {5, 6};
        send_pkt(3, 1'b0, 6'd0, PKT_ETH);
        send_pkt(2, 1'b1, 6'd1, PKT_PCIE);
        drain();

        // Metadata backpressure for 20 cycles between two packets
        send_pkt(2, 1'b1, 6'd3, PKT_ETH);
        hold_cnt = 20;
        send_pkt(3, 1'b1, 6'd7, PKT_PCIE);
        drain();

        // Randomised traffic
        mr_random = 1'b1;
        bubbles   = 1'b1;
        for (int p = 0; p < 300; p++) begin
            el_avail  = ($urandom_range(0, 9) != 0);
            mr_random = 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                send_flit(1'b0, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
            end else begin
                send_pkt(($urandom_range(0, 19) == 0) ? int'($urandom_range(29, 36)) : int'($urandom_range(1, 8)),
                         $urandom_range(0, 19) != 0, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
            end
        end
        el_avail = 1'b1;
        bubbles  = 1'b0;
        send_pkt(1, 1'b1, 6'd0, PKT_ETH);
        drain();
        check("pkt_cnt", 520'(bus.pkt_cnt), 520'(exp_pkts));
        check("drop_cnt", 520'(bus.drop_cnt), 520'(exp_drops));

        // Reset in the middle of a packet
        send_flit(1'b1, 1'b0, 6'd0, PKT_ETH);
        send_flit(1'b0, 1'b0, 6'd0, PKT_ETH);
        idle_cycles(1);
        @(negedge clk);
        bus.in_pkt_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_write", 520'(bus.pkt_buffer_write), 520'(0));
        check("midrst_meta_valid", 520'(bus.meta_valid), 520'(0));
        check("midrst_el_ready", 520'(bus.emptylist_out_ready), 520'(0));
        check("midrst_in_ready", 520'(bus.in_pkt_ready), 520'(0));
        check("midrst_pkt_cnt", 520'(bus.pkt_cnt), 520'(0));
        check("midrst_drop_cnt", 520'(bus.drop_cnt), 520'(0));
        m_mode = 0;
        exp_pkts = 0;
        exp_drops = 0;
        wq.delete();
        mq.delete();
        @(negedge clk);
        bus.in_pkt_valid = 1'b0;
        rst = 1'b0;

        // Traffic after reset
        for (int p = 0; p < 20; p++) begin
            el_avail = ($urandom_range(0, 4) != 0);
            send_pkt(int'($urandom_range(1, 5)), 1'b1, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
        end
        el_avail = 1'b1;
        drain();
        check("post_rst_pkt_cnt", 520'(bus.pkt_cnt), 520'(exp_pkts));
        check("post_rst_drop_cnt", 520'(bus.drop_cnt), 520'(exp_drops));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
